ysyx_22041412_csr_file: RTL and testbench
=========================================

Name: ysyx_22041412_csr_file

Overview:
Parametrised machine-mode CSR file for the single-issue RV64 core, replacing the fixed 6-entry CSR array.
- Decodes full 12-bit CSR addresses.
- Implements CSRRW/RS/RC and immediate variants, ECALL, MRET and machine-timer interrupt entry.
- Provides a free-running mcycle counter.
- Sits beside the EXU. Returns the read value plus a redirect PC for trap/return, one cycle after a request.

Parameters:
XLEN, 64, CSR and data width (32 or 64)
MSTATUS_RST, 64'ha00001800, mstatus reset value (truncated to XLEN)
MTVEC_RST, 0, mtvec reset value
HARTID, 0, value returned by mhartid

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_i  in  1  CSR instruction request (csr_addr_i/func3_i/wdata_i valid)
func3_i  in  3  instruction funct3: 001/101 RW, 010/110 RS, 011/111 RC; 000/100 = no CSR op
csr_addr_i  in  12  CSR address
wdata_i  in  XLEN  rs1 value or zero-extended uimm
ecall_i  in  1  ECALL request
mret_i  in  1  MRET request
irq_take_i  in  1  core accepts pending interrupt at pc_i
pc_i  in  XLEN  PC of current instruction
mtip_i  in  1  machine timer interrupt line (level)
rdata_o  out  XLEN  old CSR value (CSR op) / 0 otherwise
done_o  out  1  one-cycle completion pulse
redirect_o  out  1  with done_o: jump to redirect_pc_o
redirect_pc_o  out  XLEN  trap vector or mepc
illegal_o  out  1  with done_o: unknown CSR or write to read-only CSR
irq_pending_o  out  1  combinational: mstatus.MIE & mie.MTIE & mtip_i

Behaviour:
- Reset values:
  - mstatus=MSTATUS_RST, mtvec=MTVEC_RST; mie, mscratch, mepc, mcause, mcycle = 0.
  - All registered outputs = 0.
  - Reset mid-operation discards the request; no done_o follows.
- Supported CSRs:
  - mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342: read/write.
  - mip 0x344: read-only; bit7 = mtip_i, other bits 0.
  - mhartid 0xF14: read-only = HARTID.
  - mcycle 0xB00: read/write.
- Handshake:
  - A request (any of req_i with func3_i[1:0]!=0, ecall_i, mret_i, irq_take_i) is sampled on a clock edge while done_o=0.
  - done_o is high for exactly the next cycle; rdata_o/redirect_o/redirect_pc_o/illegal_o are valid only then and 0 otherwise.
  - Requests while done_o=1 are ignored. Back-to-back requests therefore complete every 2 cycles.
- Priority when simultaneous: rst > irq_take_i > ecall_i > mret_i > CSR op. Only one is performed.
- CSR op:
  - rdata_o = old value.
  - new = wdata_i (RW), old|wdata_i (RS), old&~wdata_i (RC).
  - RS/RC with wdata_i=0 perform no write and are legal on read-only CSRs.
  - Unknown address, or a non-zero write to a read-only CSR: illegal_o=1, rdata_o=0, no state change.
  - mepc writes clear bit0. mtvec writes clear bits[1:0] (direct mode only).
- ECALL:
  - mepc<=pc_i, mcause<=11.
  - mstatus.MPIE<=MIE, MIE<=0, MPP<=2'b11.
  - redirect_o=1, redirect_pc_o=mtvec.
- MRET:
  - mstatus.MIE<=MPIE, MPIE<=1, MPP<=2'b11.
  - redirect_o=1, redirect_pc_o=mepc (value before this cycle).
- Interrupt (irq_take_i):
  - Same as ECALL except mcause<={1'b1, (XLEN-1)'d7}.
  - If irq_pending_o=0 when irq_take_i is sampled: treat as no request, no done_o.
- mcycle:
  - Increments by 1 every cycle out of reset, wrapping at 2^XLEN-1 -> 0.
  - A CSR write to mcycle in the same cycle wins; the increment is skipped that cycle.
  - A read returns the pre-increment value.
- Masking: mstatus writes affect only MIE(3), MPIE(7), MPP(12:11); other bits hold their reset values. mie writes affect only MTIE(7).
- Sampling and update: all outputs are registered. CSR state updates on the same edge that samples the request.

Test Plan:
- Reset, then CSRRS mstatus with wdata 0 -> next cycle done_o=1, rdata_o=64'ha00001800, illegal_o=0; cycle after, done_o=0.
- CSRRW mtvec 0x80000103, then CSRRS mtvec 0 -> second read returns 0x80000100. CSRRC mscratch after RW 0xFF with 0x0F -> mscratch=0xF0.
- ECALL at pc 0x80000010 with mstatus.MIE=1 -> redirect_pc_o=mtvec, mepc=0x80000010, mcause=11, MIE=0, MPIE=1. Then MRET -> redirect_pc_o=0x80000010, MIE=1.
- mie=0x80, mstatus.MIE=1, mtip_i=1 -> irq_pending_o=1. irq_take_i at pc 0x80000040 -> mcause=0x8000000000000007, mepc=0x80000040, irq_pending_o drops (MIE=0).
- CSRRW 0x7C0 -> illegal_o=1, rdata_o=0. CSRRW mhartid 5 -> illegal_o=1. CSRRS mip 0 with mtip_i=1 -> rdata_o=0x80, legal.
- ecall_i and CSR req_i together -> only ECALL effects, CSR unchanged. Write mcycle=2^64-1 -> next read 0 after wrap. Assert rst during pending request -> no done_o.

Source files
------------

// File: rtl/ysyx_22041412_csr_file_if.sv
// Request/response bundle between the EXU and the machine-mode CSR file.
interface ysyx_22041412_csr_file_if #(
  parameter int unsigned XLEN = 64
);
  logic            req_i;
  logic [2:0]      func3_i;
  logic [11:0]     csr_addr_i;
  logic [XLEN-1:0] wdata_i;
  logic            ecall_i;
  logic            mret_i;
  logic            irq_take_i;
  logic [XLEN-1:0] pc_i;
  logic            mtip_i;
  logic [XLEN-1:0] rdata_o;
  logic            done_o;
  logic            redirect_o;
  logic [XLEN-1:0] redirect_pc_o;
  logic            illegal_o;
  logic            irq_pending_o;

  modport master (
    output req_i, func3_i, csr_addr_i, wdata_i, ecall_i, mret_i, irq_take_i, pc_i, mtip_i,
    input  rdata_o, done_o, redirect_o, redirect_pc_o, illegal_o, irq_pending_o
  );

  modport slave (
    input  req_i, func3_i, csr_addr_i, wdata_i, ecall_i, mret_i, irq_take_i, pc_i, mtip_i,
    output rdata_o, done_o, redirect_o, redirect_pc_o, illegal_o, irq_pending_o
  );
endinterface

// File: rtl/ysyx_22041412_csr_file.sv
// Machine-mode CSR file: CSR read/modify/write, ECALL, MRET, timer interrupt entry
// and a free-running mcycle. Results are registered and pulse done_o for one cycle.
module ysyx_22041412_csr_file #(
  parameter int unsigned XLEN        = 64,
  parameter logic [63:0] MSTATUS_RST = 64'ha00001800,
  parameter logic [63:0] MTVEC_RST   = 64'h0,
  parameter logic [63:0] HARTID      = 64'h0
) (
  input logic                      clk,
  input logic                      rst,
  ysyx_22041412_csr_file_if.slave  bus
);

  localparam logic [11:0] A_MSTATUS  = 12'h300;
  localparam logic [11:0] A_MIE      = 12'h304;
  localparam logic [11:0] A_MTVEC    = 12'h305;
  localparam logic [11:0] A_MSCRATCH = 12'h340;
  localparam logic [11:0] A_MEPC     = 12'h341;
  localparam logic [11:0] A_MCAUSE   = 12'h342;
  localparam logic [11:0] A_MIP      = 12'h344;
  localparam logic [11:0] A_MCYCLE   = 12'hB00;
  localparam logic [11:0] A_MHARTID  = 12'hF14;

  localparam logic [XLEN-1:0] MSTATUS_RST_X = XLEN'(MSTATUS_RST);
  localparam logic [XLEN-1:0] MTVEC_RST_X   = XLEN'(MTVEC_RST);
  localparam logic [XLEN-1:0] HARTID_X      = XLEN'(HARTID);
  localparam logic [XLEN-1:0] MSTATUS_MASK  = XLEN'(64'h1888);
  localparam logic [XLEN-1:0] MIE_MASK      = XLEN'(64'h80);
  localparam logic [XLEN-1:0] ECALL_CAUSE   = XLEN'(11);
  localparam logic [XLEN-1:0] IRQ_CAUSE     = {1'b1, (XLEN-1)'(7)};

  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mcycle_q, mcycle_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            done_q, done_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic            illegal_q, illegal_d;

  logic [XLEN-1:0] csr_rd_c;
  logic [XLEN-1:0] csr_wval_c;
  logic            known_c;
  logic            ro_c;
  logic            csr_req_c;
  logic            do_write_c;
  logic            illegal_c;
  logic            irq_pending_c;
  logic            take_irq_c;
  logic            unused_func3;

  // funct3[2] only selects register vs. immediate source, already folded into wdata_i
  assign unused_func3 = bus.func3_i[2];

  assign irq_pending_c = mstatus_q[3] & mie_q[7] & bus.mtip_i;
  assign take_irq_c    = bus.irq_take_i & irq_pending_c;
  assign csr_req_c     = bus.req_i & (bus.func3_i[1:0] != 2'b00);
  assign do_write_c    = (bus.func3_i[1:0] == 2'b01) || (bus.wdata_i != '0);
  assign illegal_c     = !known_c || (ro_c && do_write_c);

  // Address decode and read mux
  always_comb begin
    csr_rd_c = '0;
    known_c  = 1'b1;
    ro_c     = 1'b0;
    case (bus.csr_addr_i)
      A_MSTATUS:  csr_rd_c = mstatus_q;
      A_MIE:      csr_rd_c = mie_q;
      A_MTVEC:    csr_rd_c = mtvec_q;
      A_MSCRATCH: csr_rd_c = mscratch_q;
      A_MEPC:     csr_rd_c = mepc_q;
      A_MCAUSE:   csr_rd_c = mcause_q;
      A_MCYCLE:   csr_rd_c = mcycle_q;
      A_MIP: begin
        csr_rd_c = XLEN'({bus.mtip_i, 7'b0});
        ro_c     = 1'b1;
      end
      A_MHARTID: begin
        csr_rd_c = HARTID_X;
        ro_c     = 1'b1;
      end
      default:    known_c = 1'b0;
    endcase
  end

  always_comb begin
    case (bus.func3_i[1:0])
      2'b01:   csr_wval_c = bus.wdata_i;
      2'b10:   csr_wval_c = csr_rd_c | bus.wdata_i;
      2'b11:   csr_wval_c = csr_rd_c & ~bus.wdata_i;
      default: csr_wval_c = csr_rd_c;
    endcase
  end

  // Request arbitration and next state; requests are ignored while done_q is high
  always_comb begin
    mstatus_d     = mstatus_q;
    mie_d         = mie_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mcycle_d      = mcycle_q + XLEN'(1);
    rdata_d       = '0;
    done_d        = 1'b0;
    redirect_d    = 1'b0;
    redirect_pc_d = '0;
    illegal_d     = 1'b0;

    if (!done_q) begin
      if (take_irq_c || bus.ecall_i) begin
        done_d            = 1'b1;
        redirect_d        = 1'b1;
        redirect_pc_d     = mtvec_q;
        mepc_d            = bus.pc_i;
        mcause_d          = take_irq_c ? IRQ_CAUSE : ECALL_CAUSE;
        mstatus_d[7]      = mstatus_q[3];
        mstatus_d[3]      = 1'b0;
        mstatus_d[12:11]  = 2'b11;
      end else if (bus.mret_i) begin
        done_d            = 1'b1;
        redirect_d        = 1'b1;
        redirect_pc_d     = mepc_q;
        mstatus_d[3]      = mstatus_q[7];
        mstatus_d[7]      = 1'b1;
        mstatus_d[12:11]  = 2'b11;
      end else if (csr_req_c) begin
        done_d = 1'b1;
        if (illegal_c) begin
          illegal_d = 1'b1;
        end else begin
          rdata_d = csr_rd_c;
          if (do_write_c) begin
            case (bus.csr_addr_i)
              A_MSTATUS:  mstatus_d  = (csr_wval_c & MSTATUS_MASK) | (MSTATUS_RST_X & ~MSTATUS_MASK);
              A_MIE:      mie_d      = csr_wval_c & MIE_MASK;
              A_MTVEC:    mtvec_d    = {csr_wval_c[XLEN-1:2], 2'b00};
              A_MSCRATCH: mscratch_d = csr_wval_c;
              A_MEPC:     mepc_d     = {csr_wval_c[XLEN-1:1], 1'b0};
              A_MCAUSE:   mcause_d   = csr_wval_c;
              A_MCYCLE:   mcycle_d   = csr_wval_c;
              default:    ;
            endcase
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q     <= MSTATUS_RST_X;
      mie_q         <= '0;
      mtvec_q       <= MTVEC_RST_X;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mcycle_q      <= '0;
      rdata_q       <= '0;
      done_q        <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      illegal_q     <= 1'b0;
    end else begin
      mstatus_q     <= mstatus_d;
      mie_q         <= mie_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mcycle_q      <= mcycle_d;
      rdata_q       <= rdata_d;
      done_q        <= done_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      illegal_q     <= illegal_d;
    end
  end

  assign bus.rdata_o       = rdata_q;
  assign bus.done_o        = done_q;
  assign bus.redirect_o    = redirect_q;
  assign bus.redirect_pc_o = redirect_pc_q;
  assign bus.illegal_o     = illegal_q;
  assign bus.irq_pending_o = irq_pending_c;

endmodule

// File: tb/tb_ysyx_22041412_csr_file.sv
// Directed bench for the machine-mode CSR file with hand-computed expectations.
module tb_ysyx_22041412_csr_file;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  logic [63:0] r_rdata, r_pc;
  logic        r_done, r_done2, r_redir, r_ill;

  ysyx_22041412_csr_file_if #(.XLEN(64)) bus ();

  ysyx_22041412_csr_file #(.XLEN(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.req_i      = 1'b0;
    bus.func3_i    = 3'b000;
    bus.csr_addr_i = 12'h0;
    bus.wdata_i    = 64'h0;
    bus.ecall_i    = 1'b0;
    bus.mret_i     = 1'b0;
    bus.irq_take_i = 1'b0;
    bus.pc_i       = 64'h0;
  endtask

  // Inputs already driven: let one edge sample them, capture the result, then idle one cycle
  task automatic finish_txn();
    @(posedge clk); #1;
    clear_inputs();
    r_done  = bus.done_o;
    r_rdata = bus.rdata_o;
    r_redir = bus.redirect_o;
    r_pc    = bus.redirect_pc_o;
    r_ill   = bus.illegal_o;
    @(posedge clk); #1;
    r_done2 = bus.done_o;
  endtask

  task automatic csr(input logic [2:0] f3, input logic [11:0] addr, input logic [63:0] wd);
    bus.req_i      = 1'b1;
    bus.func3_i    = f3;
    bus.csr_addr_i = addr;
    bus.wdata_i    = wd;
    finish_txn();
  endtask

  task automatic csr_read(input string tag, input logic [11:0] addr, input logic [63:0] exp);
    csr(3'b010, addr, 64'h0);
    check_eq({tag, "_done"}, 64'(r_done), 64'd1);
    check_eq(tag, r_rdata, exp);
  endtask

  initial begin
    clk   = 1'b0;
    n_cmp = 0;
    n_err = 0;
    bus.mtip_i = 1'b0;
    clear_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check_eq("rst_done",    64'(bus.done_o), 64'd0);
    check_eq("rst_rdata",   bus.rdata_o, 64'h0);
    check_eq("rst_redir",   64'(bus.redirect_o), 64'd0);
    check_eq("rst_pending", 64'(bus.irq_pending_o), 64'd0);

    // Reset value of mstatus, one-cycle done pulse
    csr(3'b010, 12'h300, 64'h0);
    check_eq("mstatus_rst_done", 64'(r_done), 64'd1);
    check_eq("mstatus_rst_val",  r_rdata, 64'ha00001800);
    check_eq("mstatus_rst_ill",  64'(r_ill), 64'd0);
    check_eq("done_pulse_end",   64'(r_done2), 64'd0);

    // mtvec alignment, mscratch RW/RC
    csr(3'b001, 12'h305, 64'h80000103);
    check_eq("mtvec_rw_old", r_rdata, 64'h0);
    csr_read("mtvec_aligned", 12'h305, 64'h80000100);
    csr(3'b001, 12'h340, 64'hFF);
    csr(3'b011, 12'h340, 64'h0F);
    check_eq("mscratch_rc_old", r_rdata, 64'hFF);
    csr_read("mscratch_rc", 12'h340, 64'hF0);

    // ECALL with MIE set, then MRET
    csr(3'b110, 12'h300, 64'h8);
    check_eq("mstatus_set_old", r_rdata, 64'ha00001800);
    bus.ecall_i = 1'b1;
    bus.pc_i    = 64'h80000010;
    finish_txn();
    check_eq("ecall_redir", 64'(r_redir), 64'd1);
    check_eq("ecall_pc",    r_pc, 64'h80000100);
    check_eq("ecall_rdata", r_rdata, 64'h0);
    csr_read("ecall_mepc",    12'h341, 64'h80000010);
    csr_read("ecall_mcause",  12'h342, 64'd11);
    csr_read("ecall_mstatus", 12'h300, 64'ha00001880);
    bus.mret_i = 1'b1;
    finish_txn();
    check_eq("mret_redir", 64'(r_redir), 64'd1);
    check_eq("mret_pc",    r_pc, 64'h80000010);
    csr_read("mret_mstatus", 12'h300, 64'ha00001888);

    // Timer interrupt entry; mie masked to MTIE
    csr(3'b001, 12'h304, 64'hFFFF);
    csr_read("mie_masked", 12'h304, 64'h80);
    bus.mtip_i = 1'b1;
    #1;
    check_eq("irq_pending_hi", 64'(bus.irq_pending_o), 64'd1);
    bus.irq_take_i = 1'b1;
    bus.pc_i       = 64'h80000040;
    @(posedge clk); #1;
    clear_inputs();
    check_eq("irq_done",       64'(bus.done_o), 64'd1);
    check_eq("irq_pc",         bus.redirect_pc_o, 64'h80000100);
    check_eq("irq_pending_lo", 64'(bus.irq_pending_o), 64'd0);
    @(posedge clk); #1;
    csr_read("irq_mcause", 12'h342, 64'h8000000000000007);
    csr_read("irq_mepc",   12'h341, 64'h80000040);

    // irq_take without a pending interrupt is not a request
    bus.irq_take_i = 1'b1;
    finish_txn();
    check_eq("irq_nopend_done", 64'(r_done), 64'd0);

    // Illegal accesses and read-only CSRs
    csr(3'b001, 12'h7C0, 64'h5);
    check_eq("unknown_ill",   64'(r_ill), 64'd1);
    check_eq("unknown_rdata", r_rdata, 64'h0);
    csr(3'b001, 12'hF14, 64'h5);
    check_eq("hartid_wr_ill", 64'(r_ill), 64'd1);
    csr(3'b010, 12'hF14, 64'h0);
    check_eq("hartid_rd_ill", 64'(r_ill), 64'd0);
    check_eq("hartid_rd",     r_rdata, 64'h0);
    csr(3'b010, 12'h344, 64'h0);
    check_eq("mip_ill", 64'(r_ill), 64'd0);
    check_eq("mip_val", r_rdata, 64'h80);
    csr(3'b110, 12'h344, 64'h80);
    check_eq("mip_set_ill", 64'(r_ill), 64'd1);
    bus.mtip_i = 1'b0;

    // ECALL beats a simultaneous CSR write
    bus.ecall_i = 1'b1;
    bus.pc_i    = 64'h80000080;
    csr(3'b001, 12'h340, 64'h1234);
    check_eq("prio_redir", 64'(r_redir), 64'd1);
    check_eq("prio_rdata", r_rdata, 64'h0);
    csr_read("prio_mscratch", 12'h340, 64'hF0);
    csr_read("prio_mepc",     12'h341, 64'h80000080);

    // mepc bit0 cleared on write
    csr(3'b101, 12'h341, 64'h80000203);
    csr_read("mepc_align", 12'h341, 64'h80000202);

    // mcycle wrap: write all-ones, following reads see 0 then 2
    csr(3'b001, 12'hB00, 64'hFFFFFFFFFFFFFFFF);
    csr_read("mcycle_wrap", 12'hB00, 64'h0);
    csr_read("mcycle_incr", 12'hB00, 64'h2);

    // Reset coincident with a request: no completion, state back to reset
    csr(3'b001, 12'h340, 64'hAA);
    bus.req_i      = 1'b1;
    bus.func3_i    = 3'b001;
    bus.csr_addr_i = 12'h340;
    bus.wdata_i    = 64'h55;
    rst            = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_inputs();
    check_eq("rst_req_done", 64'(bus.done_o), 64'd0);
    @(posedge clk); #1;
    check_eq("rst_req_done2", 64'(bus.done_o), 64'd0);
    csr_read("rst_mscratch", 12'h340, 64'h0);
    csr_read("rst_mtvec",    12'h305, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
